// File: rtl/hoeraa_accumulator.sv
// ---------------------------------------------------------------------------
// hoeraa_accumulator
//   Output-stationary accumulation stage downstream of the PE multiplier.
//   A group of unsigned products (terminated by in_last) is reduced to one
//   partial sum using HOERAA approximate addition. The first term of a group
//   is loaded exactly. Later terms go through hoeraa_adder. A carry out of
//   the accumulator saturates it to all ones and sets a sticky overflow flag.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid/in_ready  product beat handshake
//   in_data            unsigned product, zero-extended to ACC_WIDTH
//   in_last            beat is the final term of its group
//   out_valid/out_ready result handshake
//   out_data           approximate saturated sum (0 while out_valid=0)
//   out_count          terms in group, saturating at 2^COUNT_WIDTH-1
//   out_overflow       saturation occurred somewhere in this group
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// hoeraa_adder
//   HOERAA approximate adder, N = ADDER_LENGTH, k = IMPRECISE_PART-1.
//   Low bits [k-2:0] are forced to one, bit k-1 is an OR, bit k is
//   approximated, and only a[k]&b[k] carries into the exact upper part.
//
// Ports
//   i_a, i_b  addends (N bits)
//   o_sum     N+1 bit result, MSB is the exact carry-out
// ---------------------------------------------------------------------------
module hoeraa_adder #(
    parameter int ADDER_LENGTH   = 32,
    parameter int IMPRECISE_PART = 16
) (
    input  logic [ADDER_LENGTH-1:0] i_a,
    input  logic [ADDER_LENGTH-1:0] i_b,
    output logic [ADDER_LENGTH:0]   o_sum
);
    localparam int N = ADDER_LENGTH;
    localparam int K = IMPRECISE_PART - 1;

    logic           w_carry;
    logic [N-K-1:0] w_hi;   // upper exact bits plus carry-out

    assign w_carry = i_a[K] & i_b[K];
    assign w_hi    = {1'b0, i_a[N-1:K+1]} + {1'b0, i_b[N-1:K+1]}
                   + {{(N-K-1){1'b0}}, w_carry};

    generate
        if (K >= 2) begin : g_ones
            assign o_sum[K-2:0] = '1;
        end
    endgenerate

    assign o_sum[K-1]   = i_a[K-1] | i_b[K-1];
    // When both k bits are set, the carry leaves and bit k is recovered
    // from the k-1 pair. Otherwise bit k is a plain OR.
    assign o_sum[K]     = w_carry ? (i_a[K-1] & i_b[K-1]) : (i_a[K] | i_b[K]);
    assign o_sum[N:K+1] = w_hi;
endmodule

module hoeraa_accumulator #(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int IMPRECISE_PART = 16,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_overflow
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_ovf;
    logic                   r_out_valid;

    logic [ACC_WIDTH-1:0]   w_in_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_beat;

    always_comb begin
        w_in_ext                 = '0;
        w_in_ext[DATA_WIDTH-1:0] = in_data;
    end

    hoeraa_adder #(
        .ADDER_LENGTH   (ACC_WIDTH),
        .IMPRECISE_PART (IMPRECISE_PART)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_in_ext),
        .o_sum (w_sum)
    );

    assign in_ready = (r_state != S_HOLD);
    assign w_beat   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        // First term is loaded exactly, no approximate add.
                        r_acc   <= w_in_ext;
                        r_count <= COUNT_WIDTH'(1);
                        r_ovf   <= 1'b0;
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        if (w_sum[ACC_WIDTH]) begin
                            r_acc <= '1;
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_WIDTH-1:0];
                        end
                        if (r_count != '1)
                            r_count <= r_count + COUNT_WIDTH'(1);
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result fields are gated so the drain stage never sees stale sums.
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_valid ? r_acc   : '0;
    assign out_count    = r_out_valid ? r_count : '0;
    assign out_overflow = r_out_valid & r_ovf;
endmodule

// File: tb/tb_hoeraa_accumulator.sv
module tb_hoeraa_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_count;
    logic       out_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hoeraa_accumulator #(
        .DATA_WIDTH     (8),
        .ACC_WIDTH      (8),
        .IMPRECISE_PART (4),
        .COUNT_WIDTH    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat, confirm the stage is ready, let one edge accept it.
    task automatic beat(input string tag, input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [7:0] d,
                          input logic [7:0] c, input logic ovf);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, "_count"}, {24'd0, out_count}, {24'd0, c});
        chk({tag, "_ovf"},   {31'd0, out_overflow}, {31'd0, ovf});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_drained_data"},  {24'd0, out_data},  32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_count", {24'd0, out_count}, 32'd0);
        chk("rst_ovf", {31'd0, out_overflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single exact beat
        beat("t1", 8'h5A, 1'b1);
        result("t1", 8'h5A, 8'd1, 1'b0);
        chk("t1_in_ready_hold", {31'd0, in_ready}, 32'd0);
        drain("t1");

        // 2: forced-one low bits, bit3 clear, exact upper 1+2
        beat("t2a", 8'h10, 1'b0);
        beat("t2b", 8'h20, 1'b1);
        result("t2", 8'h33, 8'd2, 1'b0);
        drain("t2");

        // 3: bit-k generate path carries into exact part
        beat("t3a", 8'h0C, 1'b0);
        beat("t3b", 8'h0C, 1'b1);
        result("t3", 8'h1F, 8'd2, 1'b0);
        drain("t3");

        // 4: saturation on second beat, sticky afterwards
        beat("t4a", 8'hF0, 1'b0);
        beat("t4b", 8'h20, 1'b0);
        beat("t4c", 8'h01, 1'b1);
        result("t4", 8'hFF, 8'd3, 1'b1);
        drain("t4");

        // 5: backpressure with a beat pending, then one-cycle bubble
        beat("t5a", 8'h03, 1'b1);
        in_valid = 1'b1; in_data = 8'h07; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_data", {24'd0, out_data}, 32'h03);
            chk("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_bubble_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        result("t5b", 8'h07, 8'd1, 1'b0);
        drain("t5");

        // 6: reset mid-group discards partial sum
        beat("t6a", 8'h40, 1'b0);
        beat("t6b", 8'h40, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, out_data}, 32'd0);
        chk("t6_rst_count", {24'd0, out_count}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        beat("t6c", 8'h11, 1'b1);
        result("t6", 8'h11, 8'd1, 1'b0);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
